// File: rtl/compressor3_pkg.sv
// Shared types and constants for the max-plus compressor sequencer.
// Operand value 0 is max-plus -inf, the identity for both max and saturating add.
package compressor3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REDUCE = 2'd2,
    OUT    = 2'd3
  } state_e;

  localparam logic OP_MAX = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int unsigned MP_NEG_INF = 0;

endpackage

// File: rtl/mp_combine3.sv
// Combinational 3-input max-plus combiner: max(a,b,c) or saturating a+b+c.
// Kept as its own block so it can later be swapped for the shared compressor datapath.
module mp_combine3
  import compressor3_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic         op,
  output logic [W-1:0] y,
  output logic         ovf
);

  logic [W+1:0] sum_w;
  logic [W-1:0] max_ab;
  logic [W-1:0] max_abc;

  always_comb begin
    sum_w   = {2'b00, a} + {2'b00, b} + {2'b00, c};
    max_ab  = (a > b) ? a : b;
    max_abc = (max_ab > c) ? max_ab : c;
    y       = max_abc;
    ovf     = 1'b0;
    if (op == OP_ADD) begin
      ovf = |sum_w[W+1:W];
      y   = ovf ? {W{1'b1}} : sum_w[W-1:0];
    end
  end

endmodule

// File: rtl/compressor3_sched.sv
// Packet sequencer feeding a 3-input max-plus combiner two operands per pass,
// with the running accumulator as the third input.
module compressor3_sched
  import compressor3_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic          op_sel,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic [CW-1:0] res_count,
  output logic          res_sat
);

  localparam logic [W-1:0]  NEG_INF = W'(MP_NEG_INF);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  s1_q, s1_d;
  logic [W-1:0]  s2_q, s2_d;
  logic [1:0]    slot_q, slot_d;
  logic          op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic          last_q, last_d;

  logic          accept;
  logic [W-1:0]  comb_y;
  logic          comb_ovf;

  mp_combine3 #(.W(W)) u_combine (
    .a   (acc_q),
    .b   (s1_q),
    .c   (s2_q),
    .op  (op_q),
    .y   (comb_y),
    .ovf (comb_ovf)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    slot_d  = slot_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = NEG_INF;
          s1_d    = in_data;
          s2_d    = NEG_INF;
          slot_d  = 2'd1;
          op_d    = op_sel;
          cnt_d   = CW'(1);
          sat_d   = 1'b0;
          last_d  = in_last;
          state_d = in_last ? REDUCE : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
          last_d = in_last;
          if (slot_q == 2'd0) begin
            s1_d   = in_data;
            slot_d = 2'd1;
          end else begin
            s2_d   = in_data;
            slot_d = 2'd2;
          end
          if (slot_q != 2'd0 || in_last) state_d = REDUCE;
        end
      end
      REDUCE: begin
        // Unfilled slots are still NEG_INF, so a partial final pass needs no special case.
        acc_d   = comb_y;
        sat_d   = sat_q | comb_ovf;
        s1_d    = NEG_INF;
        s2_d    = NEG_INF;
        slot_d  = 2'd0;
        state_d = last_q ? OUT : FILL;
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE) || (state_d == FILL);
    res_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      acc_q       <= NEG_INF;
      s1_q        <= NEG_INF;
      s2_q        <= NEG_INF;
      slot_q      <= 2'd0;
      op_q        <= OP_MAX;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      acc_q       <= acc_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      slot_q      <= slot_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      last_q      <= last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign res_count = cnt_q;
  assign res_sat   = sat_q;

endmodule

// File: tb/tb_compressor3_sched.sv
// Scoreboard bench for compressor3_sched: stimulus pushes expected results,
// a negedge monitor pops and compares on each result handshake.
module tb_compressor3_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       op_sel = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic [7:0] res_count;
  logic       res_sat;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
    logic       s;
  } exp_t;
  exp_t exp_q[$];

  compressor3_sched #(.W(8), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .op_sel    (op_sel),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count),
    .res_sat   (res_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] c, input logic s);
    exp_t e;
    e.d = d; e.c = c; e.s = s;
    exp_q.push_back(e);
  endtask

  // Present one operand; returns right after the accepting posedge.
  task automatic send(input logic [7:0] d, input logic l, input logic op);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; op_sel = op;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed %0d, expected 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(res_valid), 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got data %0d, expected no result", res_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", int'(res_data), int'(e.d));
        chk("res_count", int'(res_count), int'(e.c));
        chk("res_sat", int'(res_sat), int'(e.s));
      end
    end
  end

  initial begin
    int n;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_count", int'(res_count), 0);
    chk("rst_res_sat", int'(res_sat), 0);
    @(negedge clk); rst_n = 1'b1;

    // max 3,9,5,7 -> 9, latency 2 after last
    push(8'd9, 8'd4, 1'b0);
    send(8'd3, 1'b0, 1'b0);
    send(8'd9, 1'b0, 1'b0);
    send(8'd5, 1'b0, 1'b0);
    send(8'd7, 1'b1, 1'b0);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    n = 1;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 2);

    // add with saturation, then a clean add packet
    push(8'd255, 8'd3, 1'b1);
    send(8'd100, 1'b0, 1'b1);
    send(8'd100, 1'b0, 1'b1);
    send(8'd60, 1'b1, 1'b1);
    push(8'd3, 8'd2, 1'b0);
    send(8'd1, 1'b0, 1'b1);
    send(8'd2, 1'b1, 1'b1);
    idle();

    // single operand: in_ready low for exactly two cycles
    push(8'd42, 8'd1, 1'b0);
    send(8'd42, 1'b1, 1'b0);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (!in_ready) n++;
      if (i < 4) @(negedge clk);
    end
    chk("single_ready_low", n, 2);

    // consumer stall in OUT
    @(posedge clk); #1 res_ready = 1'b0;
    push(8'd6, 8'd2, 1'b0);
    send(8'd5, 1'b0, 1'b0);
    send(8'd6, 1'b1, 1'b0);
    idle();
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", int'(res_data), 6);
      chk("stall_count", int'(res_count), 2);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_res_valid", int'(res_valid), 1);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_res_valid", int'(res_valid), 0);

    // reset mid-packet drops it
    send(8'd10, 1'b0, 1'b0);
    send(8'd20, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("pre_rst_acc", int'(res_data), 20);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_res_data", int'(res_data), 0);
    chk("mid_rst_res_count", int'(res_count), 0);
    chk("mid_rst_res_sat", int'(res_sat), 0);
    @(negedge clk); rst_n = 1'b1;
    push(8'd4, 8'd2, 1'b0);
    send(8'd4, 1'b0, 1'b0);
    send(8'd1, 1'b1, 1'b0);
    idle();

    // op_sel toggling and in_valid gaps mid-packet
    push(8'd8, 8'd3, 1'b0);
    send(8'd8, 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    send(8'd2, 1'b0, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    send(8'd6, 1'b1, 1'b1);
    idle();

    // operand counter saturates at 255
    push(8'd200, 8'd255, 1'b0);
    for (int i = 1; i <= 300; i++)
      send((i == 150) ? 8'd200 : 8'd3, (i == 300), 1'b0);
    idle();

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
